grf_write_arbiter: RTL

//  Shares the single GRF write port (Enabled/A3/WD3/WPC) between NREQ writeback requesters
//  (e.g. ALU, load unit, mult/div). Per-requester valid/ready handshake, round-robin grant,
//  one registered write per cycle toward the GRF. Sits between the writeback sources and GRF.

---
 rtl/grf_write_arbiter.sv | 109 ++++++++++
 1 files changed

// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter: shares the single GRF write port between NREQ writeback
// requesters with a valid/ready handshake and a registered write toward the GRF.
// Optional build macro GRF_WARB_FIXED_PRIO_EN selects fixed priority (requester 0
// highest) instead of the default round-robin grant.
module grf_write_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               hold,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_a3,
  input  logic [NREQ*DW-1:0] req_wd,
  input  logic [NREQ*DW-1:0] req_pc,
  output logic               grf_we,
  output logic [AW-1:0]      grf_a3,
  output logic [DW-1:0]      grf_wd,
  output logic [DW-1:0]      grf_wpc,
  output logic [31:0]        wr_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] r_rr_ptr;
  logic          r_we;
  logic [AW-1:0] r_a3;
  logic [DW-1:0] r_wd;
  logic [DW-1:0] r_pc;
  logic [31:0]   r_wr_count;

  logic          w_found;
  logic [PW-1:0] w_winner;
  logic [PW-1:0] w_cand;
  logic [PW-1:0] w_ptr_nxt;
  logic [AW-1:0] w_a3;
  logic [DW-1:0] w_wd;
  logic [DW-1:0] w_pc;

  // Grant search starting at the pointer, then mux the winner's write fields.
  always_comb begin
    w_found   = 1'b0;
    w_winner  = '0;
    w_cand    = '0;
    req_ready = '0;
    w_a3      = '0;
    w_wd      = '0;
    w_pc      = '0;
    if (reset && !hold) begin
      for (int k = 0; k < NREQ; k++) begin
        w_cand = PW'((int'(r_rr_ptr) + k) % NREQ);
        if (!w_found && req_valid[w_cand]) begin
          w_found  = 1'b1;
          w_winner = w_cand;
        end
      end
      if (w_found) req_ready[w_winner] = 1'b1;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (w_found && (i == int'(w_winner))) begin
        w_a3 = req_a3[i*AW +: AW];
        w_wd = req_wd[i*DW +: DW];
        w_pc = req_pc[i*DW +: DW];
      end
    end
  end

  // Next pointer after a handshake; fixed priority pins it at requester 0.
  always_comb begin
`ifdef GRF_WARB_FIXED_PRIO_EN
    w_ptr_nxt = '0;
`else
    w_ptr_nxt = PW'((int'(w_winner) + 1) % NREQ);
`endif
  end

  // Register the granted write for one cycle, advance pointer, count commits.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rr_ptr   <= '0;
      r_we       <= 1'b0;
      r_a3       <= '0;
      r_wd       <= '0;
      r_pc       <= '0;
      r_wr_count <= '0;
    end else begin
      if (w_found) begin
        // Writes to $0 consume the requester but never reach the GRF.
        r_we     <= (w_a3 != '0);
        r_a3     <= w_a3;
        r_wd     <= w_wd;
        r_pc     <= w_pc;
        r_rr_ptr <= w_ptr_nxt;
      end else begin
        r_we <= 1'b0;
      end
      r_wr_count <= r_wr_count + {31'b0, r_we};
    end
  end

  assign grf_we   = r_we;
  assign grf_a3   = r_a3;
  assign grf_wd   = r_wd;
  assign grf_wpc  = r_pc;
  assign wr_count = r_wr_count;

endmodule
